lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 118 +++++++++++
 tb/tb_lfsr_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 32-bit XNOR LFSR pattern generator (taps 31/15).
// Seeds a local register from the first 32 received bits, then flywheels and counts mismatches.
module lfsr_checker #(
  parameter int ERR_THRESH = 4,
  parameter int WINDOW     = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [15:0]      out16
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int ERR_W = $clog2(ERR_THRESH + 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [31:0]      sr;
  logic [4:0]       fill_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [ERR_W-1:0] win_err;
  logic [ERR_W:0]   err_sum;
  logic             exp_bit;
  logic             mis;
  logic             step_locked;
  logic             mis_en;
  logic             lose_lock;
  logic             win_end;

  assign exp_bit     = ~(sr[31] ^ sr[15]);
  assign mis         = bit_in ^ exp_bit;
  assign step_locked = enable && (state == LOCKED);
  assign mis_en      = step_locked && mis;
  assign err_sum     = {1'b0, win_err} + {{ERR_W{1'b0}}, mis};
  assign win_end     = (win_cnt == WIN_W'(WINDOW - 1));

  assign locked = (state == LOCKED);
  assign out16  = sr[27:12];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    lose_lock  = 1'b0;
    case (state)
      HUNT: begin
        if (enable && (fill_cnt == 5'd31)) next_state = LOCKED;
      end
      LOCKED: begin
        if (enable && (err_sum >= (ERR_W + 1)'(ERR_THRESH))) begin
          lose_lock  = 1'b1;
          next_state = HUNT;
        end
      end
      default: next_state = HUNT;
    endcase
  end

  // While locked the register shifts in its own prediction so a corrupt bit never propagates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= 32'd0;
      fill_cnt <= 5'd0;
    end else if (enable) begin
      if (state == HUNT) begin
        sr       <= {sr[30:0], bit_in};
        fill_cnt <= fill_cnt + 5'd1;
      end else begin
        sr <= {sr[30:0], exp_bit};
        if (lose_lock) fill_cnt <= 5'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (step_locked) begin
      if (lose_lock || win_end) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        win_err <= win_err + ERR_W'(mis);
      end
    end
  end

  // A clear coinciding with a mismatch leaves that mismatch counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= mis_en;
      if (clear_err)
        err_count <= CNT_W'(mis_en);
      else if (mis_en && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a sequence-level model of generator and checker, compared every cycle.
module tb_lfsr_checker;

  localparam int ERR_THRESH = 4;
  localparam int WINDOW     = 64;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             bit_in;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [15:0]      out16;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  bit gen_seq [0:8191];
  int g_idx;

  bit m_hist [0:32767];
  int m_hlen;
  bit m_locked;
  bit m_pulse;
  bit m_mis;
  bit m_prd;
  int m_fill;
  int m_wcnt;
  int m_werr;
  int m_cnt;

  always #5 clk = ~clk;

  lfsr_checker #(
    .ERR_THRESH(ERR_THRESH),
    .WINDOW    (WINDOW),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bit_in   (bit_in),
    .clear_err(clear_err),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .out16    (out16)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit histAt(input int k);
    return (k < 0) ? 1'b0 : m_hist[k];
  endfunction

  function automatic logic [15:0] modelOut16();
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[j] = histAt(m_hlen - 13 - j);
    return r;
  endfunction

  function automatic logic [15:0] genOut16(input int n);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[j] = (n - 13 - j >= 0) ? gen_seq[n - 13 - j] : 1'b0;
    return r;
  endfunction

  // Checker model in terms of the bit history it has shifted in, not register bits.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hlen = 0; m_locked = 0; m_pulse = 0; m_fill = 0;
      m_wcnt = 0; m_werr = 0; m_cnt = 0;
    end else begin
      m_mis = 1'b0;
      if (enable) begin
        if (!m_locked) begin
          m_hist[m_hlen] = bit_in;
          m_hlen++;
          m_fill++;
          if (m_fill == 32) begin
            m_locked = 1'b1;
            m_fill   = 0;
          end
        end else begin
          m_prd = ~(histAt(m_hlen - 32) ^ histAt(m_hlen - 16));
          m_mis = (bit_in != m_prd);
          m_hist[m_hlen] = m_prd;
          m_hlen++;
          if (m_werr + int'(m_mis) >= ERR_THRESH) begin
            m_locked = 1'b0; m_fill = 0; m_wcnt = 0; m_werr = 0;
          end else if (m_wcnt == WINDOW - 1) begin
            m_wcnt = 0; m_werr = 0;
          end else begin
            m_wcnt++;
            m_werr += int'(m_mis);
          end
        end
      end
      m_pulse = m_mis;
      if (clear_err) m_cnt = int'(m_mis);
      else if (m_mis && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on && !reset) begin
      checkOutput("locked", 32'(locked), 32'(m_locked));
      checkOutput("err_pulse", 32'(err_pulse), 32'(m_pulse));
      checkOutput("err_count", 32'(err_count), 32'(m_cnt));
      checkOutput("out16", 32'(out16), 32'(modelOut16()));
    end
  end

  task automatic applyStimulus(input bit en, input bit b, input bit clr);
    @(negedge clk);
    enable    = en;
    bit_in    = b;
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendGen(input bit en, input bit flip, input bit clr);
    bit b;
    b = 1'(($urandom) % 2);
    if (en) begin
      b = gen_seq[g_idx] ^ flip;
      g_idx++;
    end
    applyStimulus(en, b, clr);
  endtask

  task automatic doReset(input bit check_async);
    @(posedge clk);
    #2;
    reset = 1'b1; enable = 1'b0; bit_in = 1'b0; clear_err = 1'b0;
    #1;
    if (check_async) begin
      checkOutput("async_locked", 32'(locked), 32'd0);
      checkOutput("async_err_count", 32'(err_count), 32'd0);
      checkOutput("async_out16", 32'(out16), 32'd0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    g_idx = 0;
  endtask

  initial begin
    logic [31:0] head;
    int pulses;
    int first_lock;

    for (int n = 0; n < 8192; n++)
      gen_seq[n] = ~(((n >= 32) ? gen_seq[n - 32] : 1'b0) ^ ((n >= 16) ? gen_seq[n - 16] : 1'b0));
    for (int i = 0; i < 32; i++) head[i] = gen_seq[i];

    reset = 1'b0; enable = 1'b0; bit_in = 1'b0; clear_err = 1'b0; g_idx = 0;
    #1 reset = 1'b1;
    #11;
    checkOutput("gen_first32", head, 32'h0000FFFF);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_err_pulse", 32'(err_pulse), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    checkOutput("reset_out16", 32'(out16), 32'd0);
    cmp_on = 1'b1;
    doReset(1'b0);

    // Lock and track
    for (int i = 0; i < 2000; i++) begin
      sendGen(1'b1, 1'b0, 1'b0);
      if (i == 30) checkOutput("t1_not_locked_31", 32'(locked), 32'd0);
      if (i == 31) begin
        checkOutput("t1_locked_32", 32'(locked), 32'd1);
        checkOutput("t1_out16_at_lock", 32'(out16), 32'h0000FFF0);
      end
      if (i >= 31) checkOutput("t1_gen_out16", 32'(out16), 32'(genOut16(g_idx)));
    end
    checkOutput("t1_err_count", 32'(err_count), 32'd0);

    // Single flip
    doReset(1'b0);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      sendGen(1'b1, i == 100, 1'b0);
      pulses += int'(err_pulse);
      if (i == 100) checkOutput("t2_pulse", 32'(err_pulse), 32'd1);
    end
    checkOutput("t2_pulses", 32'(pulses), 32'd1);
    checkOutput("t2_err_count", 32'(err_count), 32'd1);
    checkOutput("t2_locked", 32'(locked), 32'd1);

    // Burst loss and relock
    doReset(1'b0);
    for (int i = 0; i < 200; i++) begin
      sendGen(1'b1, (i == 40) || (i == 45) || (i == 50) || (i == 55), 1'b0);
      if (i == 54) checkOutput("t3_locked_before", 32'(locked), 32'd1);
      if (i == 55) begin
        checkOutput("t3_lost", 32'(locked), 32'd0);
        checkOutput("t3_err_count", 32'(err_count), 32'd4);
      end
      if (i == 86) checkOutput("t3_hunting", 32'(locked), 32'd0);
      if (i == 87) checkOutput("t3_relocked", 32'(locked), 32'd1);
      if (i >= 87) checkOutput("t3_gen_out16", 32'(out16), 32'(genOut16(g_idx)));
    end
    checkOutput("t3_final_count", 32'(err_count), 32'd4);

    // Sparse errors: three per window, never enough to drop lock
    doReset(1'b0);
    for (int i = 0; i < 32 + 10 * WINDOW + 10; i++)
      sendGen(1'b1, (i >= 32) && (i < 32 + 10 * WINDOW) &&
                    (((i - 32) % WINDOW == 5) || ((i - 32) % WINDOW == 20) || ((i - 32) % WINDOW == 40)), 1'b0);
    checkOutput("t4_locked", 32'(locked), 32'd1);
    checkOutput("t4_err_count", 32'(err_count), 32'd30);

    // Enable gaps
    doReset(1'b0);
    first_lock = -1;
    for (int c = 0; c < 6000 && g_idx < 2000; c++) begin
      bit en;
      en = 1'(($urandom) % 2);
      sendGen(en, 1'b0, 1'b0);
      if (first_lock < 0 && locked) first_lock = g_idx;
      if (!en) checkOutput("t5_pulse_after_idle", 32'(err_pulse), 32'd0);
      if (locked) checkOutput("t5_gen_out16", 32'(out16), 32'(genOut16(g_idx)));
    end
    checkOutput("t5_lock_point", 32'(first_lock), 32'd32);
    checkOutput("t5_err_count", 32'(err_count), 32'd0);

    // Reset while locked with five errors, then clear coinciding with a mismatch
    doReset(1'b0);
    for (int i = 0; i < 120; i++)
      sendGen(1'b1, (i == 40) || (i == 41) || (i == 42) || (i == 100) || (i == 101), 1'b0);
    checkOutput("t6_count5", 32'(err_count), 32'd5);
    checkOutput("t6_locked", 32'(locked), 32'd1);
    doReset(1'b1);
    for (int i = 0; i < 60; i++) begin
      sendGen(1'b1, (i == 40) || (i == 41) || (i == 50), i == 50);
      if (i == 41) checkOutput("t6_count2", 32'(err_count), 32'd2);
      if (i == 50) begin
        checkOutput("t6_clear_with_mis", 32'(err_count), 32'd1);
        checkOutput("t6_clear_keeps_lock", 32'(locked), 32'd1);
      end
    end

    // Randomized errors, gaps and clears against the model
    doReset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      bit en;
      bit flip;
      bit clr;
      en   = (($urandom) % 4) != 0;
      flip = (($urandom) % 32) == 0;
      clr  = en && ((($urandom) % 50) == 0);
      sendGen(en, flip, clr);
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
